// File: rtl/alarm_siren_ctrl.sv
// Siren/strobe annunciator controller downstream of the alarm FSM: pre-alert,
// tone-modulated sounding, user silence, auto-cutoff and re-arm holdoff.
module alarm_siren_ctrl #(
  parameter int PRE_CYCLES      = 8,
  parameter int TONE_HALF       = 4,
  parameter int MAX_ON_CYCLES   = 64,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_in,
  input  logic       ack,
  output logic       siren_out,
  output logic       strobe_out,
  output logic [2:0] state_out,
  output logic       timeout_flag
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRE      = 3'd1;
  localparam logic [2:0] S_SOUND    = 3'd2;
  localparam logic [2:0] S_SILENCED = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;

  localparam int MAX_A = (PRE_CYCLES > MAX_ON_CYCLES) ? PRE_CYCLES : MAX_ON_CYCLES;
  localparam int MAX_P = (MAX_A > COOLDOWN_CYCLES) ? MAX_A : COOLDOWN_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);
  localparam int TW    = $clog2(TONE_HALF + 1);

  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(MAX_ON_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [TW-1:0] TONE_ONE  = TW'(1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          tone_q, tone_d;
  logic          flag_q, flag_d;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      flag_q     <= flag_d;
    end
  end

  // Next-state, sticky flag, phase counter and tone generator
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (ack) flag_d = 1'b0;
        else     flag_d = flag_q;
        if (alarm_in) state_d = S_PRE;
        else          state_d = S_IDLE;
      end
      S_PRE: begin
        if (!alarm_in)              state_d = S_IDLE;
        else if (ack)               state_d = S_SILENCED;
        else if (cnt_q == PRE_LAST) state_d = S_SOUND;
        else                        state_d = S_PRE;
      end
      S_SOUND: begin
        // A dropped alarm beats the timeout, which beats ack and owns the flag
        if (!alarm_in) begin
          state_d = S_HOLDOFF;
        end else if (cnt_q == ON_LAST) begin
          state_d = S_SILENCED;
          flag_d  = 1'b1;
        end else if (ack) begin
          state_d = S_SILENCED;
        end else begin
          state_d = S_SOUND;
        end
      end
      S_SILENCED: begin
        if (ack) flag_d = 1'b0;
        else     flag_d = flag_q;
        if (!alarm_in) state_d = S_HOLDOFF;
        else           state_d = S_SILENCED;
      end
      S_HOLDOFF: begin
        if (cnt_q == COOL_LAST) state_d = S_IDLE;
        else                    state_d = S_HOLDOFF;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
    else                     cnt_d = cnt_q;

    // Siren starts high on entry to SOUND and flips every TONE_HALF cycles
    if (state_d == S_SOUND && state_q != S_SOUND) begin
      tone_d     = 1'b1;
      tone_cnt_d = '0;
    end else if (state_d == S_SOUND) begin
      if (tone_cnt_q == TONE_LAST) begin
        tone_d     = ~tone_q;
        tone_cnt_d = '0;
      end else begin
        tone_d     = tone_q;
        tone_cnt_d = tone_cnt_q + TONE_ONE;
      end
    end else begin
      tone_d     = 1'b0;
      tone_cnt_d = '0;
    end
  end

  // Moore output decode from registered state and tone
  always_comb begin
    siren_out    = 1'b0;
    strobe_out   = 1'b0;
    state_out    = state_q;
    timeout_flag = flag_q;
    case (state_q)
      S_IDLE:     begin siren_out = 1'b0;   strobe_out = 1'b0; end
      S_PRE:      begin siren_out = 1'b0;   strobe_out = 1'b1; end
      S_SOUND:    begin siren_out = tone_q; strobe_out = 1'b1; end
      S_SILENCED: begin siren_out = 1'b0;   strobe_out = 1'b1; end
      S_HOLDOFF:  begin siren_out = 1'b0;   strobe_out = 1'b0; end
      default:    begin siren_out = 1'b0;   strobe_out = 1'b0; end
    endcase
  end

endmodule
